// File: rtl/register_bank_2r1w_pkg.sv
// Shared sizing defaults and index/data types for the 2-read/1-write register bank.
// REG_ZERO is the index that REG_ZERO_HARDWIRED_EN pins to zero.
package register_bank_2r1w_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_REG_DEF  = 5;

   typedef logic [NB_REG_DEF-1:0]  reg_idx_t;
   typedef logic [NB_DATA_DEF-1:0] data_word_t;

   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/register_bank_2r1w.sv
// CPU register file: two combinational read ports, one synchronous write port.
// Define REG_ZERO_HARDWIRED_EN to make index 0 a constant-zero register.
module register_bank_2r1w
   import register_bank_2r1w_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_REG  = NB_REG_DEF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_REG-1:0]  i_read_reg1,
   input  logic [NB_REG-1:0]  i_read_reg2,
   input  logic [NB_REG-1:0]  i_write_reg,
   input  logic [NB_DATA-1:0] i_write_data,
   input  logic               i_write_enable,
   output logic [NB_DATA-1:0] o_register1,
   output logic [NB_DATA-1:0] o_register2
);

   localparam int DEPTH = 2 ** NB_REG;

   logic [NB_DATA-1:0] registers [0:DEPTH-1];
   logic               write_ok;

`ifdef REG_ZERO_HARDWIRED_EN
   localparam logic [NB_REG-1:0] IDX_ZERO = NB_REG'(REG_ZERO);

   assign write_ok    = i_write_enable && (i_write_reg != IDX_ZERO);
   assign o_register1 = (i_read_reg1 == IDX_ZERO) ? '0 : registers[i_read_reg1];
   assign o_register2 = (i_read_reg2 == IDX_ZERO) ? '0 : registers[i_read_reg2];
`else
   assign write_ok    = i_write_enable;
   assign o_register1 = registers[i_read_reg1];
   assign o_register2 = registers[i_read_reg2];
`endif

   // Reset wins over a same-edge write; no bypass, so reads see new data only after the edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            registers[i] <= '0;
         end
      end else if (write_ok) begin
         registers[i_write_reg] <= i_write_data;
      end
   end

endmodule

// File: tb/tb_register_bank_2r1w.sv
// Directed self-checking bench for register_bank_2r1w.
// Expected values for index 0 follow REG_ZERO_HARDWIRED_EN.
module tb_register_bank_2r1w;

   logic        clk;
   logic        reset;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] register1;
   logic [31:0] register2;

   int n_cmp = 0;
   int n_err = 0;

`ifdef REG_ZERO_HARDWIRED_EN
   localparam logic [31:0] EXP_R0 = 32'h0000_0000;
`else
   localparam logic [31:0] EXP_R0 = 32'hA5A5_A5A5;
`endif

   register_bank_2r1w dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_read_reg1    (read_reg1),
      .i_read_reg2    (read_reg2),
      .i_write_reg    (write_reg),
      .i_write_data   (write_data),
      .i_write_enable (write_enable),
      .o_register1    (register1),
      .o_register2    (register2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset        = 1'b1;
      read_reg1    = 5'd0;
      read_reg2    = 5'd0;
      write_reg    = 5'd0;
      write_data   = 32'h0;
      write_enable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      // every entry reads zero after reset, on both ports
      for (int a = 0; a < 32; a++) begin
         read_reg1 = 5'(a);
         read_reg2 = 5'(31 - a);
         #1;
         check($sformatf("reset_p1_%0d", a), register1, 32'h0);
         check($sformatf("reset_p2_%0d", 31 - a), register2, 32'h0);
      end

      write_reg = 5'd0; write_data = 32'hA5A5_A5A5; write_enable = 1'b1;
      @(posedge clk); #1;
      write_enable = 1'b0; read_reg1 = 5'd0;
      #1;
      check("wr0_array", dut.registers[0], EXP_R0);
      check("wr0_port1", register1, EXP_R0);

      write_reg = 5'd7; write_data = 32'hA3A3_A3A3; write_enable = 1'b1;
      @(posedge clk); #1;
      write_enable = 1'b0; read_reg1 = 5'd7;
      #1;
      check("wr7_port1", register1, 32'hA3A3_A3A3);
      check("wr7_r0_kept", dut.registers[0], EXP_R0);

      // same-cycle read during write: old value before the edge, new after
      write_reg = 5'd5; write_data = 32'h5555_0005; write_enable = 1'b1; read_reg2 = 5'd5;
      #1;
      check("rdw_before", register2, 32'h0);
      @(posedge clk); #1;
      write_enable = 1'b0;
      check("rdw_after", register2, 32'h5555_0005);

      read_reg1 = 5'd0; read_reg2 = 5'd7;
      #1;
      check("dual_p1", register1, EXP_R0);
      check("dual_p2", register2, 32'hA3A3_A3A3);

      read_reg1 = 5'd7; read_reg2 = 5'd7;
      #1;
      check("same_p1", register1, 32'hA3A3_A3A3);
      check("same_p2", register2, 32'hA3A3_A3A3);

      write_reg = 5'd7; write_data = 32'hDEAD_BEEF; write_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("wen0_array", dut.registers[7], 32'hA3A3_A3A3);
      check("wen0_port1", register1, 32'hA3A3_A3A3);

      write_reg = 5'd31; write_data = 32'h8000_0001; write_enable = 1'b1; read_reg1 = 5'd31;
      @(posedge clk); #1;
      write_enable = 1'b0;
      check("wr31_port1", register1, 32'h8000_0001);

      write_reg = 5'd3; write_data = 32'h0BAD_F00D; write_enable = 1'b1;
      @(posedge clk); #1;
      read_reg1 = 5'd3;
      #1;
      check("wr3_pre", register1, 32'h0BAD_F00D);

      // reset overrides a simultaneous write
      reset = 1'b1; write_reg = 5'd3; write_data = 32'h1234_5678; write_enable = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; write_enable = 1'b0; read_reg1 = 5'd3; read_reg2 = 5'd3;
      #1;
      check("rstwr_array", dut.registers[3], 32'h0);
      check("rstwr_p1", register1, 32'h0);
      check("rstwr_p2", register2, 32'h0);
      read_reg1 = 5'd7; read_reg2 = 5'd31;
      #1;
      check("rst_clr7", register1, 32'h0);
      check("rst_clr31", register2, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
